// File: rtl/minmax_stream_acc_if.sv
// minmax_stream_acc_if: beat-in / result-out bundle for minmax_stream_acc.
//   in_vld/in_rdy/in_val/in_idx/in_last : one local winner per upstream beat
//   out_vld/out_rdy/out_val/out_idx/out_cnt/out_ovf : frame-global result
// slave  = the accumulator stage, master = the upstream/downstream environment.
interface minmax_stream_acc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PORT       = 4,
  parameter int IDX_WIDTH  = 16
);
  localparam int LW = $clog2(PORT);
  localparam int BW = IDX_WIDTH - LW;

  logic                  in_vld;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] in_val;
  logic [LW-1:0]         in_idx;
  logic                  in_last;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_val;
  logic [IDX_WIDTH-1:0]  out_idx;
  logic [BW-1:0]         out_cnt;
  logic                  out_ovf;

  modport slave (
    input  in_vld, in_val, in_idx, in_last, out_rdy,
    output in_rdy, out_vld, out_val, out_idx, out_cnt, out_ovf
  );

  modport master (
    output in_vld, in_val, in_idx, in_last, out_rdy,
    input  in_rdy, out_vld, out_val, out_idx, out_cnt, out_ovf
  );
endinterface

// File: rtl/minmax_stream_acc.sv
// minmax_stream_acc: accumulates the running min (MINMAX=0) or max (MINMAX=1)
// over a frame of beats, each beat carrying one local winner value + lane.
// Reports frame winner value, global index {beat number, lane}, beat count
// (saturating) and an overflow flag.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : minmax_stream_acc_if.slave (beat input / result output)
//
// state  | meaning
// ST_ACC | accepting beats (in_rdy=1, out_vld=0)
// ST_OUT | presenting frame result (in_rdy=0, out_vld=1)
module minmax_stream_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int PORT       = 4,
  parameter int IDX_WIDTH  = 16,
  parameter bit MINMAX     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  minmax_stream_acc_if.slave  bus
);
  localparam int LW = $clog2(PORT);
  localparam int BW = IDX_WIDTH - LW;
  localparam logic [BW-1:0] CNT_MAX = '1;

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] acc_val_q, acc_val_d;
  logic [IDX_WIDTH-1:0]  acc_idx_q, acc_idx_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] out_val_q, out_val_d;
  logic [IDX_WIDTH-1:0]  out_idx_q, out_idx_d;
  logic [BW-1:0]         out_cnt_q, out_cnt_d;
  logic                  out_ovf_q, out_ovf_d;

  logic accept;
  logic better;

  assign accept = bus.in_vld && (state_q == ST_ACC);
  // Strict compare: ties keep the earlier beat, i.e. lowest global index wins.
  assign better = MINMAX ? (bus.in_val > acc_val_q) : (bus.in_val < acc_val_q);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    acc_val_d  = acc_val_q;
    acc_idx_d  = acc_idx_q;
    ovf_d      = ovf_q;
    out_val_d  = out_val_q;
    out_idx_d  = out_idx_q;
    out_cnt_d  = out_cnt_q;
    out_ovf_d  = out_ovf_q;

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (beat_cnt_q == '0) begin
            acc_val_d = bus.in_val;
            acc_idx_d = {{BW{1'b0}}, bus.in_idx};
          end else if (better) begin
            acc_val_d = bus.in_val;
            // Past saturation the beat field stays at CNT_MAX.
            acc_idx_d = {beat_cnt_q, bus.in_idx};
          end
          if (beat_cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (bus.in_last) begin
            state_d   = ST_OUT;
            out_val_d = acc_val_d;
            out_idx_d = acc_idx_d;
            out_cnt_d = beat_cnt_d;
            out_ovf_d = ovf_d;
          end
        end
      end
      ST_OUT: begin
        if (bus.out_rdy) begin
          state_d    = ST_ACC;
          beat_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      beat_cnt_q <= '0;
      acc_val_q  <= '0;
      acc_idx_q  <= '0;
      ovf_q      <= 1'b0;
      out_val_q  <= '0;
      out_idx_q  <= '0;
      out_cnt_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      acc_val_q  <= acc_val_d;
      acc_idx_q  <= acc_idx_d;
      ovf_q      <= ovf_d;
      out_val_q  <= out_val_d;
      out_idx_q  <= out_idx_d;
      out_cnt_q  <= out_cnt_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign bus.in_rdy  = (state_q == ST_ACC);
  assign bus.out_vld = (state_q == ST_OUT);
  assign bus.out_val = out_val_q;
  assign bus.out_idx = out_idx_q;
  assign bus.out_cnt = out_cnt_q;
  assign bus.out_ovf = out_ovf_q;
endmodule

// File: tb/tb_minmax_stream_acc.sv
// Three instances share one stimulus stream: A = MIN (IDX 16), B = MAX (IDX 16),
// C = MIN with IDX_WIDTH=4 (BW=2) for the overflow cases.
module tb_minmax_stream_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_vld = 1'b0;
  logic [15:0] in_val = '0;
  logic [1:0]  in_idx = '0;
  logic        in_last = 1'b0;
  logic        out_rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  minmax_stream_acc_if #(.DATA_WIDTH(16), .PORT(4), .IDX_WIDTH(16)) if_a ();
  minmax_stream_acc_if #(.DATA_WIDTH(16), .PORT(4), .IDX_WIDTH(16)) if_b ();
  minmax_stream_acc_if #(.DATA_WIDTH(16), .PORT(4), .IDX_WIDTH(4))  if_c ();

  assign if_a.in_vld = in_vld;  assign if_a.in_val = in_val;  assign if_a.in_idx = in_idx;
  assign if_a.in_last = in_last; assign if_a.out_rdy = out_rdy;
  assign if_b.in_vld = in_vld;  assign if_b.in_val = in_val;  assign if_b.in_idx = in_idx;
  assign if_b.in_last = in_last; assign if_b.out_rdy = out_rdy;
  assign if_c.in_vld = in_vld;  assign if_c.in_val = in_val;  assign if_c.in_idx = in_idx;
  assign if_c.in_last = in_last; assign if_c.out_rdy = out_rdy;

  minmax_stream_acc #(.DATA_WIDTH(16), .PORT(4), .IDX_WIDTH(16), .MINMAX(1'b0))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  minmax_stream_acc #(.DATA_WIDTH(16), .PORT(4), .IDX_WIDTH(16), .MINMAX(1'b1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  minmax_stream_acc #(.DATA_WIDTH(16), .PORT(4), .IDX_WIDTH(4), .MINMAX(1'b0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Drives one beat for exactly one clock edge; returns #1 after that edge.
  task automatic send_beat(input logic [15:0] v, input logic [1:0] i, input logic l);
    in_val = v; in_idx = i; in_last = l; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic bubble();
    @(posedge clk); #1;
  endtask

  task automatic release_out();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (if_a.out_vld !== 1'b0 || if_a.in_rdy !== 1'b1) begin
      failures++; $display("FAIL reset_hs got vld=%b rdy=%b want vld=0 rdy=1", if_a.out_vld, if_a.in_rdy);
    end
    checks++;
    if (if_a.out_val !== 16'd0 || if_a.out_idx !== 16'd0 || if_a.out_cnt !== 14'd0 || if_a.out_ovf !== 1'b0) begin
      failures++; $display("FAIL reset_out got val=%0d idx=%0d cnt=%0d ovf=%b want all 0",
                           if_a.out_val, if_a.out_idx, if_a.out_cnt, if_a.out_ovf);
    end
  endtask

  task automatic test_min_frame();
    send_beat(16'd50, 2'd2, 1'b0);
    send_beat(16'd20, 2'd1, 1'b0);
    checks++;
    if (if_a.out_vld !== 1'b0) begin
      failures++; $display("FAIL min_early_vld got %b want 0", if_a.out_vld);
    end
    send_beat(16'd30, 2'd3, 1'b1);
    checks++;
    if (if_a.out_vld !== 1'b1 || if_a.in_rdy !== 1'b0) begin
      failures++; $display("FAIL min_latency got vld=%b rdy=%b want vld=1 rdy=0", if_a.out_vld, if_a.in_rdy);
    end
    checks++;
    if (if_a.out_val !== 16'd20 || if_a.out_idx !== 16'd5 || if_a.out_cnt !== 14'd3 || if_a.out_ovf !== 1'b0) begin
      failures++; $display("FAIL min_result got val=%0d idx=%0d cnt=%0d ovf=%b want 20 5 3 0",
                           if_a.out_val, if_a.out_idx, if_a.out_cnt, if_a.out_ovf);
    end
    checks++;
    if (if_b.out_val !== 16'd50 || if_b.out_idx !== 16'd2 || if_b.out_cnt !== 14'd3) begin
      failures++; $display("FAIL max_same_frame got val=%0d idx=%0d cnt=%0d want 50 2 3",
                           if_b.out_val, if_b.out_idx, if_b.out_cnt);
    end
    release_out();
    checks++;
    if (if_a.out_vld !== 1'b0 || if_a.in_rdy !== 1'b1) begin
      failures++; $display("FAIL min_release got vld=%b rdy=%b want vld=0 rdy=1", if_a.out_vld, if_a.in_rdy);
    end
  endtask

  task automatic test_max_tie();
    send_beat(16'd7, 2'd3, 1'b0);
    send_beat(16'd7, 2'd0, 1'b1);
    checks++;
    if (if_b.out_vld !== 1'b1 || if_b.out_val !== 16'd7 || if_b.out_idx !== 16'd3 || if_b.out_cnt !== 14'd2) begin
      failures++; $display("FAIL max_tie got vld=%b val=%0d idx=%0d cnt=%0d want 1 7 3 2",
                           if_b.out_vld, if_b.out_val, if_b.out_idx, if_b.out_cnt);
    end
    checks++;
    if (if_a.out_idx !== 16'd3) begin
      failures++; $display("FAIL min_tie got idx=%0d want 3", if_a.out_idx);
    end
    release_out();
  endtask

  task automatic test_single_beat();
    send_beat(16'd9, 2'd2, 1'b1);
    checks++;
    if (if_b.out_vld !== 1'b1 || if_b.out_val !== 16'd9 || if_b.out_idx !== 16'd2 || if_b.out_cnt !== 14'd1) begin
      failures++; $display("FAIL single_beat got vld=%b val=%0d idx=%0d cnt=%0d want 1 9 2 1",
                           if_b.out_vld, if_b.out_val, if_b.out_idx, if_b.out_cnt);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    send_beat(16'd8, 2'd1, 1'b1);
    // Offer a tempting beat (value 0) while the result is stalled.
    in_val = 16'd0; in_idx = 2'd0; in_last = 1'b1; in_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (if_a.out_vld !== 1'b1 || if_a.in_rdy !== 1'b0 || if_a.out_val !== 16'd8 ||
          if_a.out_idx !== 16'd1 || if_a.out_cnt !== 14'd1) begin
        failures++; $display("FAIL bp_hold[%0d] got vld=%b rdy=%b val=%0d idx=%0d cnt=%0d want 1 0 8 1 1",
                             k, if_a.out_vld, if_a.in_rdy, if_a.out_val, if_a.out_idx, if_a.out_cnt);
      end
    end
    in_vld = 1'b0; in_last = 1'b0;
    release_out();
    checks++;
    if (if_a.in_rdy !== 1'b1 || if_a.out_vld !== 1'b0) begin
      failures++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", if_a.in_rdy, if_a.out_vld);
    end
    send_beat(16'd300, 2'd3, 1'b1);
    checks++;
    if (if_a.out_val !== 16'd300 || if_a.out_idx !== 16'd3 || if_a.out_cnt !== 14'd1) begin
      failures++; $display("FAIL bp_next_frame got val=%0d idx=%0d cnt=%0d want 300 3 1",
                           if_a.out_val, if_a.out_idx, if_a.out_cnt);
    end
    release_out();
  endtask

  task automatic test_bubbles();
    send_beat(16'd100, 2'd0, 1'b0); bubble();
    send_beat(16'd90,  2'd1, 1'b0); bubble();
    send_beat(16'd95,  2'd2, 1'b0); bubble();
    checks++;
    if (if_a.out_vld !== 1'b0) begin
      failures++; $display("FAIL bubble_early_vld got %b want 0", if_a.out_vld);
    end
    send_beat(16'd10,  2'd0, 1'b1);
    checks++;
    if (if_a.out_vld !== 1'b1 || if_a.out_val !== 16'd10 || if_a.out_idx !== 16'd12 || if_a.out_cnt !== 14'd4) begin
      failures++; $display("FAIL bubbles got vld=%b val=%0d idx=%0d cnt=%0d want 1 10 12 4",
                           if_a.out_vld, if_a.out_val, if_a.out_idx, if_a.out_cnt);
    end
    release_out();
  endtask

  task automatic test_overflow();
    send_beat(16'd5, 2'd0, 1'b0);
    send_beat(16'd6, 2'd1, 1'b0);
    send_beat(16'd7, 2'd2, 1'b0);
    send_beat(16'd8, 2'd3, 1'b0);
    send_beat(16'd1, 2'd1, 1'b1);
    checks++;
    if (if_c.out_vld !== 1'b1 || if_c.out_val !== 16'd1 || if_c.out_idx !== 4'd13 ||
        if_c.out_cnt !== 2'd3 || if_c.out_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_c got vld=%b val=%0d idx=%0d cnt=%0d ovf=%b want 1 1 13 3 1",
                           if_c.out_vld, if_c.out_val, if_c.out_idx, if_c.out_cnt, if_c.out_ovf);
    end
    checks++;
    if (if_a.out_idx !== 16'd17 || if_a.out_cnt !== 14'd5 || if_a.out_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_a got idx=%0d cnt=%0d ovf=%b want 17 5 0",
                           if_a.out_idx, if_a.out_cnt, if_a.out_ovf);
    end
    release_out();
    send_beat(16'd3, 2'd2, 1'b1);
    checks++;
    if (if_c.out_ovf !== 1'b0 || if_c.out_cnt !== 2'd1 || if_c.out_idx !== 4'd2 || if_c.out_val !== 16'd3) begin
      failures++; $display("FAIL ovf_next got val=%0d idx=%0d cnt=%0d ovf=%b want 3 2 1 0",
                           if_c.out_val, if_c.out_idx, if_c.out_cnt, if_c.out_ovf);
    end
    release_out();
  endtask

  task automatic test_async_reset();
    send_beat(16'd40, 2'd0, 1'b0);
    send_beat(16'd41, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.out_val !== 16'd0 || if_a.out_idx !== 16'd0 || if_a.out_cnt !== 14'd0 ||
        if_c.out_ovf !== 1'b0 || if_a.out_vld !== 1'b0 || if_a.in_rdy !== 1'b1) begin
      failures++; $display("FAIL async_rst got val=%0d idx=%0d cnt=%0d vld=%b rdy=%b want 0 0 0 0 1",
                           if_a.out_val, if_a.out_idx, if_a.out_cnt, if_a.out_vld, if_a.in_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(16'd4, 2'd1, 1'b1);
    checks++;
    if (if_a.out_vld !== 1'b1 || if_a.out_val !== 16'd4 || if_a.out_idx !== 16'd1 || if_a.out_cnt !== 14'd1) begin
      failures++; $display("FAIL post_rst got vld=%b val=%0d idx=%0d cnt=%0d want 1 4 1 1",
                           if_a.out_vld, if_a.out_val, if_a.out_idx, if_a.out_cnt);
    end
    release_out();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_min_frame();
    test_max_tie();
    test_single_beat();
    test_backpressure();
    test_bubbles();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
